noc_vc_fifo: RTL
================

# noc_vc_fifo

Multi-channel (virtual-channel) generalisation of the general-purpose FIFO, sitting in the network interface between the flit packetiser and the router injection port. It holds NUM_VC independent FIFO queues in one shared storage array, with one write port and one read port, each steered by a VC index. Per-VC full/almost-full/empty/occupancy status drives upstream credit logic and the VC arbiter. A sticky error flag records overflow and underflow.

## Interface
- WIDTH, 32, flit width in bits
- DEPTH, 8, entries per VC; power of two, at least 2
- NUM_VC, 4, number of virtual channels; power of two, at least 2
- AF_THRESH, 6, per-VC occupancy at or above which almost_full is asserted; range 1..DEPTH
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- write_en  in  1  write request
- write_vc  in  VC_W  target VC of write (VC_W = clog2(NUM_VC))
- data_in  in  WIDTH  write data
- read_en  in  1  read request
- read_vc  in  VC_W  source VC of read
- data_out  out  WIDTH  read data, registered
- data_valid  out  1  data_out holds a flit popped last cycle
- full  out  NUM_VC  per-VC full
- almost_full  out  NUM_VC  per-VC ocup >= AF_THRESH
- empty  out  NUM_VC  per-VC empty
- ocup  out  NUM_VC*(AW+1)  flattened per-VC occupancy, VC0 in LSBs (AW = clog2(DEPTH))
- error  out  1  sticky overflow/underflow flag
- error_clr  in  1  clears error

## Operation
- Storage: one array of NUM_VC*DEPTH words, addressed {vc, ptr}; per VC an AW-bit write pointer, AW-bit read pointer, (AW+1)-bit count.
- Write accepted when write_en and (not full[write_vc], or read_en with read_vc==write_vc and not empty[read_vc]); word stored at {write_vc, wptr}, wptr increments modulo DEPTH (natural wrap).
- Write to a full VC with no same-VC read: dropped, error set, pointers/count unchanged.
- Read accepted when read_en and not empty[read_vc]; data_out loads {read_vc, rptr} next edge, data_valid=1 for one cycle, rptr increments modulo DEPTH.
- Read of an empty VC: data_out holds previous value, data_valid=0, error set. No write-to-read bypass: a same-cycle write to that empty VC is still accepted, the read still errors.
- Count per VC: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. Different-VC read and write are fully independent.
- full = (count==DEPTH); empty = (count==0); almost_full = (count>=AF_THRESH); all combinational from count.
- error: set on any overflow/underflow; error_clr clears; set wins over clear in the same cycle.
- Reset: all pointers/counts 0, data_out=0, data_valid=0, error=0. So empty=all ones, full=0, almost_full=0, ocup=0. Storage not cleared. Reset mid-operation discards all queued flits.

## Timing
- Write-to-status: count/full/empty/ocup update on the edge that accepts the write; a flit written at edge N is readable from the cycle after edge N.
- Read latency: 1 cycle; read_en sampled at edge N, data_out/data_valid valid after edge N.
- Back-to-back reads of the same or different VCs at full rate, one per cycle.
- Status outputs are glitch-free functions of registers; no combinational path from inputs to outputs.

## Structure
- Shared header noc_fifo_defs.vh: clog2 function, VC_W/AW derivation macros, ocup slice macro, all reused by arbiter and credit counters.
- One sub-module, noc_vc_fifo_ctrl: per-VC pointer/count/status registers, instantiated NUM_VC times via generate. Top holds storage, read register, error and port steering.
- Target 150-250 lines RTL.

## Test plan
- Reset then idle: empty=4'b1111, full=0, ocup=0, error=0, data_valid=0.
- Write 0x0101A5A5, 0x0000BBBB, 0x00010001 to VC1; read VC1 three cycles -> data_out those values in order, data_valid high 3 cycles; ocup VC1 goes 1,2,3 then 2,1,0; other VCs stay empty.
- Fill VC2 with 8 words -> almost_full[2] after 6th, full[2] after 8th; 9th write -> dropped, error=1; read 8 -> original order, including after pointer wrap (write 4, read 4, write 8, read 8).
- Full VC0 with simultaneous write 0xCCCC0000 and read VC0 -> write accepted, ocup stays 8, no error; 0xCCCC0000 emerges last.
- Read empty VC3 with simultaneous write 0x0100CCCC to VC3 -> data_valid=0, error=1, ocup VC3=1; next-cycle read returns 0x0100CCCC; error_clr then clears error.
- Interleaved writes to VC0/VC3 with reset asserted mid-stream -> all counts 0 next cycle, data_valid=0, error=0.

Source files
------------

// File: rtl/noc_vc_fifo_pkg.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo_pkg
// Shared definitions for the virtual-channel FIFO: default parameter values,
// the clog2 helper used to size VC indices, pointers and counters, the
// bit-offset helper for the flattened occupancy bus, and the per-VC counter
// operation encoding.
// -----------------------------------------------------------------------------
package noc_vc_fifo_pkg;

  localparam int WIDTH_DEF     = 32'sd32;
  localparam int DEPTH_DEF     = 32'sd8;
  localparam int NUM_VC_DEF    = 32'sd4;
  localparam int AF_THRESH_DEF = 32'sd6;

  // Ceiling log2, evaluated at elaboration time for widths.
  function automatic int clog2(input int value);
    int result;
    result = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < value) begin
        result = i + 32'sd1;
      end else begin
        result = result;
      end
    end
    return result;
  endfunction

  // LSB position of a VC's occupancy field in the flattened ocup bus.
  function automatic int ocup_lsb(input int vc, input int aw);
    return vc * (aw + 32'sd1);
  endfunction

  // Per-VC counter operation, encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    CNT_HOLD = 2'b00,
    CNT_DEC  = 2'b01,
    CNT_INC  = 2'b10,
    CNT_BOTH = 2'b11
  } cnt_op_e;

endpackage

// File: rtl/noc_vc_fifo_if.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo_if
// Handshake/bus bundle between the flit packetiser (master) and the VC FIFO
// (slave).
//   master drives : write_en, write_vc, data_in, read_en, read_vc, error_clr
//   slave drives  : data_out, data_valid, full, almost_full, empty, ocup, error
// ocup is flattened per VC, VC0 in the LSBs, (AW+1) bits per VC.
// -----------------------------------------------------------------------------
interface noc_vc_fifo_if #(
  parameter int WIDTH  = 32'sd32,
  parameter int DEPTH  = 32'sd8,
  parameter int NUM_VC = 32'sd4
);
  import noc_vc_fifo_pkg::*;

  localparam int VC_W = clog2(NUM_VC);
  localparam int AW   = clog2(DEPTH);

  logic                       write_en;
  logic [VC_W-1:0]            write_vc;
  logic [WIDTH-1:0]           data_in;
  logic                       read_en;
  logic [VC_W-1:0]            read_vc;
  logic                       error_clr;
  logic [WIDTH-1:0]           data_out;
  logic                       data_valid;
  logic [NUM_VC-1:0]          full;
  logic [NUM_VC-1:0]          almost_full;
  logic [NUM_VC-1:0]          empty;
  logic [NUM_VC*(AW+1)-1:0]   ocup;
  logic                       error;

  modport master (
    output write_en, write_vc, data_in, read_en, read_vc, error_clr,
    input  data_out, data_valid, full, almost_full, empty, ocup, error
  );

  modport slave (
    input  write_en, write_vc, data_in, read_en, read_vc, error_clr,
    output data_out, data_valid, full, almost_full, empty, ocup, error
  );

endinterface

// File: rtl/noc_vc_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo_ctrl
// Bookkeeping for one virtual channel: write pointer, read pointer and
// occupancy count, plus full/almost-full/empty decoded from the count.
// Acceptance is decided by the parent; this block only applies it.
//   clk, reset      : clock, synchronous active-high reset
//   wr_acc_i        : a write to this VC is accepted this cycle
//   rd_acc_i        : a read from this VC is accepted this cycle
//   wptr_o, rptr_o  : current pointers within this VC's slice of storage
//   count_o         : occupancy, 0..DEPTH
//   full_o, almost_full_o, empty_o : status decoded from count_o
// -----------------------------------------------------------------------------
module noc_vc_fifo_ctrl
  import noc_vc_fifo_pkg::*;
#(
  parameter int DEPTH     = DEPTH_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_acc_i,
  input  logic                    rd_acc_i,
  output logic [clog2(DEPTH)-1:0] wptr_o,
  output logic [clog2(DEPTH)-1:0] rptr_o,
  output logic [clog2(DEPTH):0]   count_o,
  output logic                    full_o,
  output logic                    almost_full_o,
  output logic                    empty_o
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 32'sd1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] ZERO_C  = CW'(0);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  cnt_op_e       op_s;

  // Next-state for pointers and count; pointers wrap naturally at DEPTH.
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    op_s    = cnt_op_e'({wr_acc_i, rd_acc_i});

    if (wr_acc_i) begin
      wptr_d = wptr_q + PTR_ONE;
    end else begin
      wptr_d = wptr_q;
    end

    if (rd_acc_i) begin
      rptr_d = rptr_q + PTR_ONE;
    end else begin
      rptr_d = rptr_q;
    end

    // Simultaneous push and pop leaves occupancy unchanged.
    case (op_s)
      CNT_INC:  count_d = count_q + ONE_C;
      CNT_DEC:  count_d = count_q - ONE_C;
      CNT_HOLD: count_d = count_q;
      CNT_BOTH: count_d = count_q;
      default:  count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  assign wptr_o        = wptr_q;
  assign rptr_o        = rptr_q;
  assign count_o       = count_q;
  assign full_o        = (count_q == DEPTH_C);
  assign empty_o       = (count_q == ZERO_C);
  assign almost_full_o = (count_q >= AF_C);

endmodule

// File: rtl/noc_vc_fifo.sv
// -----------------------------------------------------------------------------
// noc_vc_fifo
// NUM_VC independent FIFO queues sharing one storage array of NUM_VC*DEPTH
// words addressed {vc, ptr}. One write port and one read port, each steered
// by a VC index. Read data is registered (1-cycle latency). A sticky error
// flag records dropped writes (VC full) and failed reads (VC empty).
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of noc_vc_fifo_if (requests in, data/status out)
// -----------------------------------------------------------------------------
module noc_vc_fifo
  import noc_vc_fifo_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int NUM_VC    = NUM_VC_DEF,
  parameter int AF_THRESH = AF_THRESH_DEF
) (
  input  logic          clk,
  input  logic          reset,
  noc_vc_fifo_if.slave  bus
);

  localparam int VC_W    = clog2(NUM_VC);
  localparam int AW      = clog2(DEPTH);
  localparam int CW      = AW + 32'sd1;
  localparam int ENTRIES = NUM_VC * DEPTH;
  localparam int ADDR_W  = VC_W + AW;

  logic [WIDTH-1:0]     mem_q [ENTRIES];

  logic [AW-1:0]        wptr_s  [NUM_VC];
  logic [AW-1:0]        rptr_s  [NUM_VC];
  logic [CW-1:0]        count_s [NUM_VC];
  logic [NUM_VC-1:0]    full_s;
  logic [NUM_VC-1:0]    af_s;
  logic [NUM_VC-1:0]    empty_s;
  logic [NUM_VC-1:0]    wr_sel_s;
  logic [NUM_VC-1:0]    rd_sel_s;
  logic [NUM_VC*CW-1:0] ocup_s;

  logic                 rd_acc_s;
  logic                 wr_acc_s;
  logic                 same_vc_s;
  logic                 err_set_s;
  logic [ADDR_W-1:0]    waddr_s;
  logic [ADDR_W-1:0]    raddr_s;

  logic [WIDTH-1:0]     data_out_q, data_out_d;
  logic                 data_valid_q, data_valid_d;
  logic                 error_q, error_d;

  // Port acceptance. A write to a full VC still goes in when the same VC is
  // popped this cycle, since the pop frees the slot the write lands in.
  always_comb begin
    rd_acc_s  = bus.read_en & ~empty_s[bus.read_vc];
    same_vc_s = (bus.read_vc == bus.write_vc);
    wr_acc_s  = bus.write_en & (~full_s[bus.write_vc] | (rd_acc_s & same_vc_s));
    waddr_s   = {bus.write_vc, wptr_s[bus.write_vc]};
    raddr_s   = {bus.read_vc, rptr_s[bus.read_vc]};
    err_set_s = (bus.write_en & ~wr_acc_s) | (bus.read_en & ~rd_acc_s);
  end

  // Steer the accepted write/read to the owning VC's bookkeeping.
  always_comb begin
    wr_sel_s = '0;
    rd_sel_s = '0;
    for (int v = 32'sd0; v < NUM_VC; v++) begin
      wr_sel_s[v] = wr_acc_s & (bus.write_vc == VC_W'(v));
      rd_sel_s[v] = rd_acc_s & (bus.read_vc == VC_W'(v));
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_VC; g++) begin : g_vc
      noc_vc_fifo_ctrl #(
        .DEPTH     (DEPTH),
        .AF_THRESH (AF_THRESH)
      ) u_ctrl (
        .clk           (clk),
        .reset         (reset),
        .wr_acc_i      (wr_sel_s[g]),
        .rd_acc_i      (rd_sel_s[g]),
        .wptr_o        (wptr_s[g]),
        .rptr_o        (rptr_s[g]),
        .count_o       (count_s[g]),
        .full_o        (full_s[g]),
        .almost_full_o (af_s[g]),
        .empty_o       (empty_s[g])
      );

      assign ocup_s[ocup_lsb(g, AW) +: CW] = count_s[g];
    end
  endgenerate

  // Shared storage; deliberately not reset. When a full VC is written and
  // read together, wptr equals rptr, and the read register below captures
  // the old word before this edge overwrites it.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_q[waddr_s] <= bus.data_in;
    end
  end

  // Next-state for read data, valid strobe and sticky error (set beats clear).
  always_comb begin
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    error_d      = error_q;

    if (rd_acc_s) begin
      data_out_d   = mem_q[raddr_s];
      data_valid_d = 1'b1;
    end else begin
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
    end

    if (err_set_s) begin
      error_d = 1'b1;
    end else if (bus.error_clr) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      error_q      <= error_d;
    end
  end

  assign bus.data_out    = data_out_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.full        = full_s;
  assign bus.almost_full = af_s;
  assign bus.empty       = empty_s;
  assign bus.ocup        = ocup_s;
  assign bus.error       = error_q;

endmodule
